sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Two-master Avalon-MM arbiter in front of the single SDRAM controller slave
//  (16-bit, 32 MB part on sdram_*). Shares the controller between master 0
//  (CPU data path) and master 1 (DMA/streaming client) using round-robin with
//  a bounded burst lock. Routes pipelined read data back to the issuing master
//  through an in-order ID FIFO. Sits between the masters and the controller.
// PARAMETERS
//  ADDR_W       24  word address width (2 bank + 13 row + 9 col)
//  DATA_W       16  data width; byteenable width BE_W = DATA_W/8
//  MAX_PEND      8  max outstanding reads (ID FIFO depth, power of 2)
//  GRANT_BEATS   4  max accepted transfers per grant before forced re-arbitration
// PORTS
//  clk_clk           in   1       system clock
//  reset_reset       in   1       async reset, active-high
//  mN_address        in   ADDR_W  master N (N=0,1) word address
//  mN_read/mN_write  in   1       master N read/write request (mutually exclusive)
//  mN_writedata      in   DATA_W  master N write data
//  mN_byteenable     in   BE_W    master N byte enables
//  mN_waitrequest    out  1       stall to master N
//  mN_readdata       out  DATA_W  read data (s_readdata broadcast)
//  mN_readdatavalid  out  1       read data valid for master N
//  s_address         out  ADDR_W  to controller
//  s_read/s_write    out  1       to controller
//  s_writedata       out  DATA_W  to controller
//  s_byteenable      out  BE_W    to controller
//  s_waitrequest     in   1       controller stall
//  s_readdata        in   DATA_W  controller read data
//  s_readdatavalid   in   1       controller read data valid
//  err_unexp_rdv     out  1       sticky: readdatavalid with empty ID FIFO
// BEHAVIOUR
//  Reset: state IDLE, last_grant=1 (m0 wins first tie), beat_cnt=0, FIFO empty,
//   s_read=s_write=0, mN_waitrequest=1, mN_readdatavalid=0, err_unexp_rdv=0.
//  FSM IDLE/GNT0/GNT1 (registered). reqN = mN_read|mN_write.
//   IDLE: req0&req1 -> GNT of master != last_grant; single req -> its GNT; else stay.
//   GNTx: accept = s_(read|write) & !s_waitrequest; beat_cnt++ on accept.
//    release when (accept & beat_cnt==GRANT_BEATS-1) or !reqx (no pending cmd).
//    On release: other master requesting -> GNT(other) next cycle (no bubble);
//    only x requesting after beat-limit release -> GNTx again, beat_cnt=0; else IDLE.
//    last_grant <= x on entry to GNTx.
//  Datapath combinational mux: in GNTx s_* = mx_*, mx_waitrequest = s_waitrequest
//   (or 1 if read blocked); non-granted master waitrequest=1; IDLE: s_read=s_write=0.
//  Latency: request seen in IDLE at cycle t -> s_read/s_write earliest t+1.
//   Read data path adds 0 cycles (readdatavalid combinational from FIFO head).
//  ID FIFO: push granted ID on read accept; pop on s_readdatavalid;
//   mN_readdatavalid = s_readdatavalid & !empty & head==N.
//   Push+pop same cycle: count unchanged. Count==MAX_PEND: granted master's read
//   blocked (s_read=0, waitrequest=1); writes unaffected; pop frees slot, read
//   issued next cycle. Pointers wrap modulo MAX_PEND.
//  s_readdatavalid with empty FIFO: no mN_readdatavalid, err_unexp_rdv set until reset.
//  Reset mid-transfer: all state cleared immediately; outstanding reads discarded
//   (controller shares reset_reset).
//  Address/data never modified; writes never enter the ID FIFO.
// TESTING
//  m0 read, addr 0x000010, only requester -> s_read at t+1; data 0xBEEF to m0 only.
//  m0,m1 continuous reads from t=0 -> grants m0x4, m1x4, m0x4...; no idle cycle at
//   hand-over.
//  m1 issues 8 reads, controller holds readdatavalid -> 9th read stalled
//   (m1_waitrequest=1); one readdatavalid -> 9th issued next cycle.
//  m0 write 0x1234 be=2'b01 while m1 reads outstanding -> write proceeds, m1 gets
//   all read data in order.
//  s_waitrequest held 5 cycles mid-grant -> master held, s_* stable, no switch.
//  Readdatavalid with no reads pending -> err_unexp_rdv=1; reset mid-burst -> all
//   outputs to reset values.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one Avalon-MM SDRAM controller slave between two masters.
// Round-robin arbitration with a bounded burst lock, and an in-order ID FIFO
// that steers pipelined read data back to whichever master issued the read.
module sdram_port_arbiter #(
    parameter int  ADDR_W      = 24,
    parameter int  DATA_W      = 16,
    parameter int  MAX_PEND    = 8,
    parameter int  GRANT_BEATS = 4,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    // master 0 (CPU data path)
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    // master 1 (DMA / streaming client)
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    // SDRAM controller slave
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    // sticky protocol error
    output logic              err_unexp_rdv
);

    localparam int PW  = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int BCW = (GRANT_BEATS > 1) ? $clog2(GRANT_BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic [BCW-1:0]   r_beat_cnt;
    logic [BCW-1:0]   w_beat_cnt_next;

    // read-ID FIFO: one bit per outstanding read (which master issued it)
    logic             r_fifo_id [MAX_PEND];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_err;

    // per-master request vectors, indexed by master number
    logic [1:0]       w_m_read;
    logic [1:0]       w_m_write;
    logic [ADDR_W-1:0] w_m_address   [2];
    logic [DATA_W-1:0] w_m_writedata [2];
    logic [BE_W-1:0]   w_m_byteenable[2];
    logic [1:0]       w_req;
    logic [1:0]       w_wait;
    logic [1:0]       w_rdv;

    logic             w_granted;
    logic             w_gnt_id;
    logic             w_sel_read;
    logic             w_sel_write;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_rd_block;
    logic             w_s_read;
    logic             w_s_write;
    logic             w_wait_sel;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_head_id;
    logic             w_limit;

    assign w_m_read          = {m1_read, m0_read};
    assign w_m_write         = {m1_write, m0_write};
    assign w_m_address[0]    = m0_address;
    assign w_m_address[1]    = m1_address;
    assign w_m_writedata[0]  = m0_writedata;
    assign w_m_writedata[1]  = m1_writedata;
    assign w_m_byteenable[0] = m0_byteenable;
    assign w_m_byteenable[1] = m1_byteenable;

    assign w_granted    = (r_state != ST_IDLE);
    assign w_gnt_id     = (r_state == ST_GNT1);
    assign w_sel_read   = w_m_read[w_gnt_id];
    assign w_sel_write  = w_m_write[w_gnt_id];

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == (PW+1)'(MAX_PEND));
    assign w_head_id    = r_fifo_id[r_rd_ptr];

    // A read from the granted master is held off while every ID slot is in use.
    assign w_rd_block   = w_granted & w_sel_read & w_fifo_full;
    assign w_s_read     = w_granted & w_sel_read & ~w_fifo_full;
    assign w_s_write    = w_granted & w_sel_write;
    assign w_wait_sel   = s_waitrequest | w_rd_block;
    assign w_accept     = (w_s_read | w_s_write) & ~s_waitrequest;
    assign w_push       = w_accept & w_s_read;
    assign w_pop        = s_readdatavalid & ~w_fifo_empty;
    assign w_limit      = w_accept & (r_beat_cnt == BCW'(GRANT_BEATS - 1));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign w_req[gi]  = w_m_read[gi] | w_m_write[gi];
            assign w_wait[gi] = ~w_granted | (w_gnt_id != 1'(gi)) | w_wait_sel;
            assign w_rdv[gi]  = w_pop & (w_head_id == 1'(gi));
        end
    endgenerate

    assign s_read           = w_s_read;
    assign s_write          = w_s_write;
    assign s_address        = w_m_address[w_gnt_id];
    assign s_writedata      = w_m_writedata[w_gnt_id];
    assign s_byteenable     = w_m_byteenable[w_gnt_id];

    assign m0_waitrequest   = w_wait[0];
    assign m1_waitrequest   = w_wait[1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_rdv[0];
    assign m1_readdatavalid = w_rdv[1];
    assign err_unexp_rdv    = r_err;

    // Next grant and burst counter: round-robin, re-arbitrate on burst limit or idle owner.
    always_comb begin
        w_state_next    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                w_beat_cnt_next = '0;
                if (w_req[0] & w_req[1]) begin
                    w_state_next = r_last_grant ? ST_GNT0 : ST_GNT1;
                end else if (w_req[0]) begin
                    w_state_next = ST_GNT0;
                end else if (w_req[1]) begin
                    w_state_next = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (w_limit | ~w_req[w_gnt_id]) begin
                    w_beat_cnt_next = '0;
                    if (w_req[~w_gnt_id]) begin
                        w_state_next = w_gnt_id ? ST_GNT0 : ST_GNT1;
                    end else if (w_limit & w_req[w_gnt_id]) begin
                        w_state_next = r_state;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_accept) begin
                    w_beat_cnt_next = r_beat_cnt + BCW'(1);
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_beat_cnt_next = '0;
            end
        endcase
    end

    // Grant state, burst counter and round-robin history.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_beat_cnt_next;
            if (w_state_next == ST_GNT0) begin
                r_last_grant <= 1'b0;
            end else if (w_state_next == ST_GNT1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // ID FIFO pointers, occupancy and the sticky unexpected-data flag.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (s_readdatavalid & w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr] <= w_gnt_id;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Randomised and directed stimulus against a transaction-level reference model
// of the two-master arbiter (grant owner, burst count, queue of read owners).
module tb_sdram_port_arbiter;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 16;
    localparam int MAX_PEND    = 8;
    localparam int GRANT_BEATS = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [1:0]        m0_byteenable = '0, m1_byteenable = '0;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [1:0]        s_byteenable;
    logic              s_waitrequest = 1'b0;
    logic [DATA_W-1:0] s_readdata = '0;
    logic              s_readdatavalid = 1'b0;
    logic              err_unexp_rdv;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND), .GRANT_BEATS(GRANT_BEATS)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_unexp_rdv(err_unexp_rdv)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: owner -1 = nobody, else master index
    int md_owner = -1;
    int md_last  = 1;
    int md_beats = 0;
    int md_q[$];
    bit md_err   = 1'b0;

    // stimulus control and observation bookkeeping
    bit auto_m = 1'b0;
    bit ctrl_manual = 1'b0;
    int wait_pct = 0;
    int rdv_pct = 0;
    int pend_ctrl = 0;
    int n_acc[2] = '{0, 0};
    int n_rdv[2] = '{0, 0};
    logic [DATA_W-1:0] last_rd[2];
    logic [DATA_W-1:0] last_wd;
    logic [1:0]        last_be;
    int acc_log[$];

    function automatic void model_reset();
        md_owner = -1;
        md_last  = 1;
        md_beats = 0;
        md_q.delete();
        md_err   = 1'b0;
    endfunction

    task automatic new_cmd(input int n);
        bit req, isrd;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [1:0] b;
        req  = ($urandom_range(99) < 70);
        isrd = $urandom_range(1);
        a    = ADDR_W'($urandom);
        d    = DATA_W'($urandom);
        b    = 2'($urandom_range(3, 1));
        if (n == 0) begin
            m0_read = req && isrd; m0_write = req && !isrd;
            m0_address = a; m0_writedata = d; m0_byteenable = b;
        end else begin
            m1_read = req && isrd; m1_write = req && !isrd;
            m1_address = a; m1_writedata = d; m1_byteenable = b;
        end
    endtask

    // One clock cycle: check outputs against the model mid-cycle, advance model, drive next inputs.
    task automatic step();
        logic rd[2], wr[2], wt[2], rq[2];
        logic [ADDR_W-1:0] ad[2];
        logic [DATA_W-1:0] wd[2];
        logic [1:0] be[2];
        bit got[2];
        bit full, blk, esr, esw, acc, lim, rel;
        bit ewait[2];
        int x, nxt, acc_id;
        @(negedge clk_clk);
        rd = '{m0_read, m1_read};  wr = '{m0_write, m1_write};
        ad = '{m0_address, m1_address}; wd = '{m0_writedata, m1_writedata};
        be = '{m0_byteenable, m1_byteenable}; wt = '{m0_waitrequest, m1_waitrequest};
        rq[0] = rd[0] | wr[0]; rq[1] = rd[1] | wr[1];
        esr = 0; esw = 0; ewait = '{1'b1, 1'b1}; x = md_owner; blk = 0;
        if (x >= 0) begin
            full     = (md_q.size() == MAX_PEND);
            blk      = rd[x] && full;
            esr      = rd[x] && !blk;
            esw      = wr[x];
            ewait[x] = s_waitrequest || blk;
        end
        chk("s_read", 32'(s_read), 32'(esr));
        chk("s_write", 32'(s_write), 32'(esw));
        if (esr || esw) chk("s_address", 32'(s_address), 32'(ad[x]));
        if (esw) begin
            chk("s_writedata", 32'(s_writedata), 32'(wd[x]));
            chk("s_byteenable", 32'(s_byteenable), 32'(be[x]));
        end
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(ewait[0]));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(ewait[1]));
        chk("m0_readdatavalid", 32'(m0_readdatavalid),
            32'(s_readdatavalid && md_q.size() > 0 && md_q[0] == 0));
        chk("m1_readdatavalid", 32'(m1_readdatavalid),
            32'(s_readdatavalid && md_q.size() > 0 && md_q[0] == 1));
        if (s_readdatavalid) begin
            chk("m0_readdata", 32'(m0_readdata), 32'(s_readdata));
            chk("m1_readdata", 32'(m1_readdata), 32'(s_readdata));
        end
        chk("err_unexp_rdv", 32'(err_unexp_rdv), 32'(md_err));

        // bookkeeping from what the DUT actually did (drives stimulus only)
        acc_id = -1;
        for (int n = 0; n < 2; n++) begin
            got[n] = rq[n] && !wt[n];
            if (got[n]) begin
                n_acc[n]++;
                acc_id = n;
                $display("[%0t] m%0d %s addr=%06h wdata=%04h", $time, n,
                         rd[n] ? "RD" : "WR", ad[n], wd[n]);
            end
        end
        acc_log.push_back(acc_id);
        if (s_write && !s_waitrequest) begin
            last_wd = s_writedata;
            last_be = s_byteenable;
        end
        if (s_read && !s_waitrequest) pend_ctrl++;
        if (s_readdatavalid) begin
            if (pend_ctrl > 0) pend_ctrl--;
            if (m0_readdatavalid) begin n_rdv[0]++; last_rd[0] = m0_readdata; end
            if (m1_readdatavalid) begin n_rdv[1]++; last_rd[1] = m1_readdata; end
            $display("[%0t] rdata=%04h rdv0=%0b rdv1=%0b", $time, s_readdata,
                     m0_readdatavalid, m1_readdatavalid);
        end

        // advance the reference model
        acc = (esr || esw) && !s_waitrequest;
        if (s_readdatavalid) begin
            if (md_q.size() > 0) void'(md_q.pop_front());
            else md_err = 1'b1;
        end
        if (acc && esr) md_q.push_back(x);
        rel = 0;
        if (x < 0) begin
            if (rq[0] && rq[1]) nxt = (md_last == 1) ? 0 : 1;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else begin
            if (acc) md_beats++;
            lim = acc && (md_beats == GRANT_BEATS);
            rel = lim || !rq[x];
            if (!rel)            nxt = x;
            else if (rq[1 - x])  nxt = 1 - x;
            else if (lim)        nxt = x;
            else                 nxt = -1;
            if (rel) md_beats = 0;
        end
        if (nxt >= 0) md_last = nxt;
        md_owner = nxt;

        @(posedge clk_clk);
        #1;
        if (auto_m) begin
            for (int n = 0; n < 2; n++) if (got[n] || !rq[n]) new_cmd(n);
        end
        if (!ctrl_manual) begin
            s_waitrequest   = ($urandom_range(99) < wait_pct);
            s_readdatavalid = (pend_ctrl > 0) && ($urandom_range(99) < rdv_pct);
            s_readdata      = DATA_W'($urandom);
        end
    endtask

    // Assert reset mid-cycle and confirm outputs drop to reset values at once.
    task automatic do_reset();
        reset_reset     = 1'b1;
        s_readdatavalid = 1'b0;
        #1;
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_s_write", 32'(s_write), 0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("rst_m1_rdv", 32'(m1_readdatavalid), 0);
        chk("rst_err", 32'(err_unexp_rdv), 0);
        model_reset();
        pend_ctrl = 0;
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
    endtask

    task automatic drain();
        int i;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        auto_m = 0; ctrl_manual = 0; rdv_pct = 100; wait_pct = 0;
        for (i = 0; i < 64 && (md_q.size() > 0 || pend_ctrl > 0 || md_owner >= 0); i++) step();
        if (i == 64) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int base, b0, b1, r0, r1;
        logic [ADDR_W-1:0] hold_addr;

        do_reset();
        step();

        // single requester: m0 read of 0x000010, data 0xBEEF returned to m0 only
        acc_log.delete();
        b0 = n_acc[0]; r0 = n_rdv[0]; r1 = n_rdv[1];
        m0_read = 1; m0_address = 24'h000010;
        step();
        step();
        m0_read = 0;
        chk("t1_idle_cycle", 32'(acc_log[0]), 32'(-1));
        chk("t1_issue_next", 32'(acc_log[1]), 0);
        ctrl_manual = 1; s_readdatavalid = 1; s_readdata = 16'hBEEF;
        step();
        s_readdatavalid = 0; ctrl_manual = 0;
        chk("t1_m0_rdv", 32'(n_rdv[0] - r0), 1);
        chk("t1_m1_rdv", 32'(n_rdv[1] - r1), 0);
        chk("t1_data", 32'(last_rd[0]), 32'h0000BEEF);
        drain();

        // both masters reading continuously from reset: bursts of four, no bubble
        do_reset();
        wait_pct = 0; rdv_pct = 100; s_waitrequest = 0;
        m0_read = 1; m0_address = 24'h000100;
        m1_read = 1; m1_address = 24'h000200;
        acc_log.delete();
        repeat (17) step();
        chk("t2_first_idle", 32'(acc_log[0]), 32'(-1));
        for (int k = 1; k <= 16; k++) chk("t2_rr_seq", 32'(acc_log[k]), 32'(((k - 1) / 4) % 2));
        drain();

        // ID FIFO full: ninth m1 read stalls until one readdatavalid frees a slot
        rdv_pct = 0; wait_pct = 0;
        base = n_acc[1];
        m1_read = 1; m1_address = 24'h000300;
        repeat (9) step();
        chk("t3_eight_reads", 32'(n_acc[1] - base), 8);
        step();
        chk("t3_ninth_blocked", 32'(n_acc[1] - base), 8);
        chk("t3_m1_wait", 32'(m1_waitrequest), 1);
        chk("t3_s_read_off", 32'(s_read), 0);
        ctrl_manual = 1; s_readdatavalid = 1; s_readdata = 16'h5A5A;
        step();
        ctrl_manual = 0; s_readdatavalid = 0;
        chk("t3_pop_cycle", 32'(n_acc[1] - base), 8);
        step();
        chk("t3_ninth_issued", 32'(n_acc[1] - base), 9);
        drain();

        // m0 write while m1 reads are outstanding
        rdv_pct = 0; wait_pct = 0;
        base = n_acc[1];
        m1_read = 1; m1_address = 24'h000400;
        for (int i = 0; i < 20 && n_acc[1] < base + 3; i++) step();
        m1_read = 0;
        chk("t4_m1_reads", 32'(n_acc[1] - base), 3);
        b0 = n_acc[0]; r0 = n_rdv[0]; r1 = n_rdv[1];
        m0_write = 1; m0_address = 24'h000500; m0_writedata = 16'h1234; m0_byteenable = 2'b01;
        for (int i = 0; i < 20 && n_acc[0] == b0; i++) step();
        m0_write = 0;
        chk("t4_write_acc", 32'(n_acc[0] - b0), 1);
        chk("t4_wdata", 32'(last_wd), 32'h1234);
        chk("t4_be", 32'(last_be), 32'h1);
        drain();
        chk("t4_m1_data", 32'(n_rdv[1] - r1), 3);
        chk("t4_m0_data", 32'(n_rdv[0] - r0), 0);

        // controller stall mid-grant: owner held, no switch, beat count resumes
        rdv_pct = 100; wait_pct = 0;
        m0_read = 1; m0_address = 24'h000600;
        step();
        m1_read = 1; m1_address = 24'h000700;
        step();
        b0 = n_acc[0]; b1 = n_acc[1];
        ctrl_manual = 1; s_waitrequest = 1; s_readdatavalid = 0;
        hold_addr = s_address;
        repeat (5) step();
        chk("t5_stall_m0", 32'(n_acc[0] - b0), 0);
        chk("t5_stall_m1", 32'(n_acc[1] - b1), 0);
        chk("t5_addr_stable", 32'(s_address), 32'(hold_addr));
        ctrl_manual = 0; s_waitrequest = 0;
        acc_log.delete();
        repeat (4) step();
        chk("t5_after0", 32'(acc_log[0]), 0);
        chk("t5_after1", 32'(acc_log[1]), 0);
        chk("t5_after2", 32'(acc_log[2]), 0);
        chk("t5_after3", 32'(acc_log[3]), 1);
        drain();

        // readdatavalid with nothing pending sets the sticky error
        ctrl_manual = 1; s_readdatavalid = 1; s_readdata = 16'hDEAD;
        step();
        s_readdatavalid = 0;
        step();
        ctrl_manual = 0;
        chk("t6_err_set", 32'(err_unexp_rdv), 1);

        // reset in the middle of busy traffic
        auto_m = 1; wait_pct = 0; rdv_pct = 50;
        repeat (6) step();
        do_reset();
        step();

        // random traffic, then a phase with slow read return to exercise a full FIFO
        auto_m = 1; wait_pct = 25; rdv_pct = 50;
        repeat (800) step();
        rdv_pct = 8;
        repeat (800) step();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
